// File: rtl/multicycle_controller_v2_if.sv
// Control bundle between the multicycle controller and its datapath.
// master: controller side (takes instruction fields/flags, drives controls).
// slave: datapath side (drives instruction fields/flags, takes controls).
interface multicycle_controller_v2_if;
  // instruction fields, ALU flags and memory completion
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       MemReady;
  // datapath controls and debug state
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemReq;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero, Lt, Ltu, MemReady,
    output ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc,
           AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Illegal, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Lt, Ltu, MemReady,
    input  ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc,
           AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller_v2.sv
// Multicycle RV32I-subset controller: FSM sequencing fetch/decode/execute/writeback.
// Latency: 3-5 states per instruction plus memory wait cycles; controls decode from current state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while MemReady=0 (when MEM_HANDSHAKE=1).
// Ports: clk, reset (sync, active-low), bus (master modport: instruction fields/flags in, controls out).
module multicycle_controller_v2 #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_JALR  = 1'b1,
  parameter bit SUPPORT_UPPER = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_v2_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6,  ALUWB   = 4'd7,
    EXECI    = 4'd8,  JAL    = 4'd9,  BRANCH = 4'd10, JALR    = 4'd11,
    LUI      = 4'd12, AUIPC  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t     state;
  logic       mem_rdy;
  logic       op_legal;
  logic       br_taken;
  logic [3:0] alu_dec;
  logic       irw, pcw, rw, mw, mr, ill;

  // With the handshake disabled every memory access completes in its first cycle.
  assign mem_rdy = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL: op_legal = 1'b1;
      OP_BR:             op_legal = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011);
      OP_JALR:           op_legal = SUPPORT_JALR;
      OP_LUI, OP_AUIPC:  op_legal = SUPPORT_UPPER;
      default:           op_legal = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (bus.funct3)
      3'b000:  br_taken = bus.Zero;
      3'b001:  br_taken = !bus.Zero;
      3'b100:  br_taken = bus.Lt;
      3'b101:  br_taken = !bus.Lt;
      3'b110:  br_taken = bus.Ltu;
      3'b111:  br_taken = !bus.Ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // sub only exists for R-type; I-type funct3=000 is always addi even if bit 30 is set.
  always_comb begin
    alu_dec = ALU_ADD;
    case (bus.funct3)
      3'b000:  alu_dec = (bus.op == OP_R && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    bus.ImmSrc = 3'b000;
    case (bus.op)
      OP_SW:            bus.ImmSrc = 3'b001;
      OP_BR:            bus.ImmSrc = 3'b010;
      OP_JAL:           bus.ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
      default:          bus.ImmSrc = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_rdy) state <= DECODE;
        DECODE: begin
          if (!op_legal) state <= FETCH;
          else begin
            case (bus.op)
              OP_LW, OP_SW: state <= MEMADR;
              OP_R:         state <= EXECR;
              OP_I:         state <= EXECI;
              OP_JAL:       state <= JAL;
              OP_BR:        state <= BRANCH;
              OP_JALR:      state <= JALR;
              OP_LUI:       state <= LUI;
              default:      state <= AUIPC;
            endcase
          end
        end
        MEMADR:   state <= (bus.op == OP_SW) ? MEMWRITE : ((bus.op == OP_LW) ? MEMREAD : FETCH);
        MEMREAD:  if (mem_rdy) state <= MEMWB;
        MEMWRITE: if (mem_rdy) state <= FETCH;
        EXECR, EXECI, JAL, LUI, AUIPC: state <= (state == JAL || state == LUI ||
                                                 state == AUIPC || state == EXECR ||
                                                 state == EXECI) ? ALUWB : FETCH;
        JALR:     state <= JAL;
        default:  state <= FETCH;  // MEMWB, ALUWB, BRANCH and unused encodings
      endcase
    end
  end

  always_comb begin
    bus.ALUControl = ALU_ADD;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.AdrSrc     = 1'b0;
    irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; mr = 1'b0; ill = 1'b0;
    case (state)
      FETCH:    begin mr = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
                      irw = mem_rdy; pcw = mem_rdy; end
      DECODE:   begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01; ill = !op_legal; end
      MEMADR:   begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; end
      MEMREAD:  begin bus.AdrSrc = 1'b1; mr = 1'b1; end
      MEMWB:    begin bus.ResultSrc = 2'b01; rw = 1'b1; end
      MEMWRITE: begin bus.AdrSrc = 1'b1; mr = 1'b1; mw = 1'b1; end
      EXECR:    begin bus.ALUSrcA = 2'b10; bus.ALUControl = alu_dec; end
      ALUWB:    rw = 1'b1;
      EXECI:    begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; bus.ALUControl = alu_dec; end
      JAL:      begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; pcw = 1'b1; end
      BRANCH:   begin bus.ALUSrcA = 2'b10; bus.ALUControl = ALU_SUB; pcw = br_taken; end
      JALR:     begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; end
      LUI:      begin bus.ALUSrcA = 2'b11; bus.ALUSrcB = 2'b01; end
      AUIPC:    begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01; end
      default:  ;
    endcase
  end

  // Enables are squashed combinationally while reset is held low.
  assign bus.IRWrite  = reset & irw;
  assign bus.PCWrite  = reset & pcw;
  assign bus.RegWrite = reset & rw;
  assign bus.MemWrite = reset & mw;
  assign bus.MemReq   = reset & mr;
  assign bus.Illegal  = reset & ill;
  assign bus.State    = state;

endmodule

// File: tb/tb_multicycle_controller_v2.sv
// Bench for multicycle_controller_v2: default-parameter DUT plus a DUT with
// handshake, jalr and upper-immediate support disabled; per-cycle model compare
// plus directed literal expectations.
module tb_multicycle_controller_v2;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, JAL = 7'b1101111, BR = 7'b1100011,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  // per-state operand selects and ALU base codes by funct3
  localparam int TA[14] = '{0, 1, 2, 0, 0, 0, 2, 0, 2, 1, 2, 2, 3, 1};
  localparam int TB[14] = '{2, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 1};
  localparam int AL[8]  = '{0, 7, 5, 6, 4, 8, 3, 2};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = LW;
  logic [6:0] op1 = LUI;
  logic [6:0] op1_next = LUI;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  int checks = 0;
  int errors = 0;

  bit mh[2] = '{1'b1, 1'b0};
  bit sj[2] = '{1'b1, 1'b0};
  bit su[2] = '{1'b1, 1'b0};
  int m_st[2] = '{0, 0};
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller_v2_if bus0();
  multicycle_controller_v2_if bus1();

  assign bus0.op = op;        assign bus1.op = op1;
  assign bus0.funct3 = funct3; assign bus1.funct3 = funct3;
  assign bus0.funct7b5 = funct7b5; assign bus1.funct7b5 = funct7b5;
  assign bus0.Zero = zero;    assign bus1.Zero = zero;
  assign bus0.Lt = lt;        assign bus1.Lt = lt;
  assign bus0.Ltu = ltu;      assign bus1.Ltu = ltu;
  assign bus0.MemReady = mem_ready; assign bus1.MemReady = mem_ready;

  multicycle_controller_v2 #(.MEM_HANDSHAKE(1'b1), .SUPPORT_JALR(1'b1), .SUPPORT_UPPER(1'b1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  multicycle_controller_v2 #(.MEM_HANDSHAKE(1'b0), .SUPPORT_JALR(1'b0), .SUPPORT_UPPER(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [23:0] obs[2];
  assign obs[0] = {bus0.ImmSrc, bus0.ALUControl, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc,
                   bus0.AdrSrc, bus0.IRWrite, bus0.PCWrite, bus0.RegWrite, bus0.MemWrite,
                   bus0.MemReq, bus0.Illegal, bus0.State};
  assign obs[1] = {bus1.ImmSrc, bus1.ALUControl, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ResultSrc,
                   bus1.AdrSrc, bus1.IRWrite, bus1.PCWrite, bus1.RegWrite, bus1.MemWrite,
                   bus1.MemReq, bus1.Illegal, bus1.State};

  function automatic bit legal(int k, logic [6:0] o, logic [2:0] f3);
    if (o == LW || o == SW || o == RT || o == IT || o == JAL) return 1'b1;
    if (o == BR) return !(f3 == 3'd2 || f3 == 3'd3);
    if (o == JALR) return sj[k];
    if (o == LUI || o == AUIPC) return su[k];
    return 1'b0;
  endfunction

  // Next state: the successor along the instruction's state path; memory
  // states repeat while the access is not complete.
  function automatic int next_state(int k, int s);
    int p[5];
    int n;
    logic [6:0] o;
    logic rdy;
    o = (k != 0) ? op1 : op;
    rdy = mh[k] ? mem_ready : 1'b1;
    p = '{0, 1, 0, 0, 0};
    n = 2;
    if (legal(k, o, funct3)) begin
      if (o == LW)         begin p[2] = 2;  p[3] = 3; p[4] = 4; n = 5; end
      else if (o == SW)    begin p[2] = 2;  p[3] = 5; n = 4; end
      else if (o == RT)    begin p[2] = 6;  p[3] = 7; n = 4; end
      else if (o == IT)    begin p[2] = 8;  p[3] = 7; n = 4; end
      else if (o == JAL)   begin p[2] = 9;  p[3] = 7; n = 4; end
      else if (o == BR)    begin p[2] = 10; n = 3; end
      else if (o == JALR)  begin p[2] = 11; p[3] = 9; p[4] = 7; n = 5; end
      else if (o == LUI)   begin p[2] = 12; p[3] = 7; n = 4; end
      else                 begin p[2] = 13; p[3] = 7; n = 4; end
    end
    if ((s == 0 || s == 3 || s == 5) && !rdy) return s;
    for (int i = 0; i < n; i++) if (p[i] == s) return (i + 1 < n) ? p[i + 1] : 0;
    return 0;
  endfunction

  function automatic logic [23:0] exp_vec(int k);
    int s;
    logic [6:0] o;
    logic rdy, go, taken, adr, irw, pcw, rw, mw, mr, ill;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [1:0] a, b, r;
    s = m_st[k];
    o = (k != 0) ? op1 : op;
    rdy = mh[k] ? mem_ready : 1'b1;
    go = reset;
    imm = (o == SW) ? 3'd1 : (o == BR) ? 3'd2 : (o == JAL) ? 3'd3 :
          (o == LUI || o == AUIPC) ? 3'd4 : 3'd0;
    a = 2'(TA[s]);
    b = 2'(TB[s]);
    r = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
    adr = (s == 3 || s == 5);
    alu = 4'd0;
    if (s == 10) alu = 4'd1;
    if (s == 6 || s == 8) begin
      alu = 4'(AL[funct3]);
      if (funct3 == 3'd0 && s == 6 && funct7b5) alu = 4'd1;
      if (funct3 == 3'd5 && funct7b5) alu = 4'd9;
    end
    taken = (funct3[2] ? (funct3[1] ? ltu : lt) : zero) ^ funct3[0];
    irw = go && s == 0 && rdy;
    pcw = go && ((s == 0 && rdy) || s == 9 || (s == 10 && taken));
    rw  = go && (s == 4 || s == 7);
    mw  = go && s == 5;
    mr  = go && (s == 0 || s == 3 || s == 5);
    ill = go && s == 1 && !legal(k, o, funct3);
    return {imm, alu, a, b, r, adr, irw, pcw, rw, mw, mr, ill, 4'(s)};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_st[0] = 0; m_st[1] = 0; model_on = 1'b1;
    end else if (model_on) begin
      for (int k = 0; k < 2; k++) m_st[k] = next_state(k, m_st[k]);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL cycle_outputs dut%0d at %0t: got %h expected %h", k, $time, obs[k], exp_vec(k));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One cycle: inputs change 2ns after the rising edge, task returns on the falling edge.
  task automatic cyc(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic rdy, input logic z);
    @(posedge clk);
    #2;
    reset = r; op = o; funct3 = f3; funct7b5 = f7; mem_ready = rdy; zero = z; op1 = op1_next;
    #3;
  endtask

  initial begin
    int  tr[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
    logic rd[10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0};

    cyc(0, LW, 0, 0, 0, 0);
    cyc(0, LW, 0, 0, 0, 0);
    chk("rst_state", bus0.State, 0);
    chk("rst_memreq", bus0.MemReq, 0);
    chk("rst_irwrite", bus0.IRWrite, 0);

    // lw with two wait cycles in FETCH and in MEMREAD
    for (int i = 0; i < 10; i++) begin
      cyc(1, LW, 0, 0, rd[i], 0);
      chk($sformatf("lw_state[%0d]", i), bus0.State, tr[i]);
      chk($sformatf("lw_irwrite[%0d]", i), bus0.IRWrite, (i == 2) ? 1 : 0);
      chk($sformatf("lw_regwrite[%0d]", i), bus0.RegWrite, (i == 8) ? 1 : 0);
      if (i == 0) chk("first_fetch_memreq", bus0.MemReq, 1);
      if (i == 8) chk("model_pin_memwb", m_st[0], 4);
    end

    // bne not taken-equal (Zero=0 -> taken), then Zero=1 -> not taken
    cyc(1, BR, 1, 0, 1, 0); cyc(1, BR, 1, 0, 1, 0); cyc(1, BR, 1, 0, 1, 0);
    chk("bne0_state", bus0.State, 10);
    chk("bne0_pcwrite", bus0.PCWrite, 1);
    chk("bne0_alu", bus0.ALUControl, 1);
    cyc(1, BR, 1, 0, 1, 1); cyc(1, BR, 1, 0, 1, 1); cyc(1, BR, 1, 0, 1, 1);
    chk("bne1_pcwrite", bus0.PCWrite, 0);
    chk("bne1_alu", bus0.ALUControl, 1);

    // jalr: trace 1,11,9,7,0
    cyc(1, JALR, 0, 0, 1, 0);
    cyc(1, JALR, 0, 0, 1, 0); chk("jalr_t0", bus0.State, 1);
    cyc(1, JALR, 0, 0, 1, 0); chk("jalr_t1", bus0.State, 11);
    chk("jalr_srca", bus0.ALUSrcA, 2); chk("jalr_srcb", bus0.ALUSrcB, 1);
    chk("model_pin_jalr", m_st[0], 11);
    cyc(1, JALR, 0, 0, 1, 0); chk("jalr_t2", bus0.State, 9); chk("jal_pcwrite", bus0.PCWrite, 1);
    cyc(1, JALR, 0, 0, 1, 0); chk("jalr_t3", bus0.State, 7); chk("jalr_regwrite", bus0.RegWrite, 1);
    cyc(1, JALR, 0, 0, 0, 0); chk("jalr_t4", bus0.State, 0);

    // sub, addi with bit30 set, srai
    cyc(1, RT, 0, 1, 1, 0); cyc(1, RT, 0, 1, 1, 0); cyc(1, RT, 0, 1, 1, 0);
    chk("sub_state", bus0.State, 6); chk("sub_alu", bus0.ALUControl, 1);
    cyc(1, RT, 0, 1, 1, 0);
    cyc(1, IT, 0, 1, 1, 0); cyc(1, IT, 0, 1, 1, 0); cyc(1, IT, 0, 1, 1, 0);
    chk("addi_state", bus0.State, 8); chk("addi_alu", bus0.ALUControl, 0);
    cyc(1, IT, 0, 1, 1, 0);
    cyc(1, IT, 5, 1, 1, 0); cyc(1, IT, 5, 1, 1, 0); cyc(1, IT, 5, 1, 1, 0);
    chk("srai_alu", bus0.ALUControl, 9);
    cyc(1, IT, 5, 1, 1, 0);
    cyc(1, IT, 5, 1, 0, 0);

    // branch funct3=010 is illegal
    cyc(1, BR, 2, 0, 1, 0);
    cyc(1, BR, 2, 0, 1, 0); chk("br010_illegal", bus0.Illegal, 1); chk("br010_pcwrite", bus0.PCWrite, 0);
    cyc(1, BR, 2, 0, 0, 0); chk("br010_next", bus0.State, 0); chk("br010_illegal_off", bus0.Illegal, 0);

    // lui: illegal on dut1, executes on dut0
    cyc(0, LUI, 0, 0, 0, 0);
    cyc(1, LUI, 0, 0, 1, 0); chk("lui1_fetch", bus1.State, 0);
    cyc(1, LUI, 0, 0, 1, 0);
    chk("lui1_state", bus1.State, 1); chk("lui1_illegal", bus1.Illegal, 1);
    chk("lui1_regwrite", bus1.RegWrite, 0); chk("lui1_pcwrite", bus1.PCWrite, 0);
    chk("lui1_memwrite", bus1.MemWrite, 0); chk("lui1_irwrite", bus1.IRWrite, 0);
    chk("lui0_illegal", bus0.Illegal, 0);
    cyc(1, LUI, 0, 0, 1, 0);
    chk("lui1_next", bus1.State, 0); chk("lui1_illegal_off", bus1.Illegal, 0);
    chk("lui0_state", bus0.State, 12); chk("lui0_srca", bus0.ALUSrcA, 3);
    cyc(1, LUI, 0, 0, 1, 0); chk("lui0_wb", bus0.RegWrite, 1);

    // sw held in MEMWRITE, then reset mid-wait; dut1 runs lw with no handshake
    op1_next = LW;
    cyc(0, SW, 0, 0, 0, 0);
    cyc(1, SW, 0, 0, 1, 0); chk("nohs_t0", bus1.State, 0);
    cyc(1, SW, 0, 0, 1, 0); chk("nohs_t1", bus1.State, 1);
    cyc(1, SW, 0, 0, 1, 0); chk("sw_memadr", bus0.State, 2); chk("nohs_t2", bus1.State, 2);
    cyc(1, SW, 0, 0, 0, 0);
    chk("sw_wait_state", bus0.State, 5); chk("sw_wait_memwrite", bus0.MemWrite, 1);
    chk("nohs_t3", bus1.State, 3);
    cyc(0, SW, 0, 0, 0, 0);
    chk("sw_rst_memwrite", bus0.MemWrite, 0); chk("sw_rst_memreq", bus0.MemReq, 0);
    chk("nohs_t4", bus1.State, 4); chk("nohs_rst_regwrite", bus1.RegWrite, 0);
    cyc(1, SW, 0, 0, 0, 0); chk("sw_rst_next", bus0.State, 0);

    // jal and auipc on dut0
    cyc(1, JAL, 0, 0, 1, 0); cyc(1, JAL, 0, 0, 1, 0); cyc(1, JAL, 0, 0, 1, 0);
    chk("jal_state", bus0.State, 9); chk("jal_imm", bus0.ImmSrc, 3);
    cyc(1, JAL, 0, 0, 1, 0);
    cyc(1, AUIPC, 0, 0, 1, 0); cyc(1, AUIPC, 0, 0, 1, 0); cyc(1, AUIPC, 0, 0, 1, 0);
    chk("auipc_state", bus0.State, 13); chk("auipc_srca", bus0.ALUSrcA, 1);
    cyc(1, AUIPC, 0, 0, 1, 0); chk("auipc_wb", bus0.RegWrite, 1);
    cyc(1, AUIPC, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller_v2.md
MULTICYCLE_CONTROLLER_V2 -- requirements
Module: multicycle_controller_v2

Interface
REQ-001 The module SHALL have parameter MEM_HANDSHAKE, default 1, meaning FSM waits on MemReady; 0 means MemReady is ignored and treated as 1.
REQ-002 The module SHALL have parameter SUPPORT_JALR, default 1, meaning jalr (1100111) is decoded; 0 means jalr is illegal.
REQ-003 The module SHALL have parameter SUPPORT_UPPER, default 1, meaning lui (0110111) and auipc (0010111) are decoded; 0 means both are illegal.
REQ-004 The module SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The module SHALL have port reset, input, 1, with one clock; reset is synchronous and active-low.
REQ-006 The module SHALL have inputs op 7, funct3 3 and funct7b5 1, carrying instruction fields.
REQ-007 The module SHALL have inputs Zero, Lt and Ltu, 1 each, carrying ALU flags for rs1-rs2: equal, signed less, unsigned less.
REQ-008 The module SHALL have input MemReady, 1, meaning the memory access completes this cycle.
REQ-009 The module SHALL have outputs ImmSrc 3 (000 I, 001 S, 010 B, 011 J, 100 U) and ALUControl 4.
REQ-010 The module SHALL have outputs ALUSrcA 2 (00 PC, 01 OldPC, 10 rs1, 11 zero) and ALUSrcB 2 (00 rs2, 01 Imm, 10 const 4).
REQ-011 The module SHALL have output ResultSrc 2 (00 ALUOut, 01 Data, 10 ALUResult).
REQ-012 The module SHALL have outputs AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq and Illegal, 1 each.
REQ-013 The module SHALL have output State, 4, the current FSM state for debug.

Function
REQ-014 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, JALR 11, LUI 12, AUIPC 13; encodings 14 and 15 SHALL output all enables 0 and go to FETCH.
REQ-015 FETCH SHALL drive: MemReq=1, AdrSrc=0, A=00, B=10, add, ResultSrc=10, and IRWrite=PCWrite=MemReady. It SHALL stay in FETCH while MemReady=0 and go to DECODE on MemReady=1.
REQ-016 DECODE SHALL drive: A=01, B=01, add. Next state by op: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, jal->JAL, branch->BRANCH, jalr->JALR, lui->LUI, auipc->AUIPC.
REQ-017 In DECODE, an unsupported op, a disabled op, or branch funct3 010/011 SHALL assert Illegal for exactly that cycle, write nothing, and go to FETCH.
REQ-018 MEMADR SHALL drive A=10, B=01, add. It SHALL go to MEMREAD for lw and to MEMWRITE for sw.
REQ-019 MEMREAD SHALL drive AdrSrc=1, MemReq=1, ResultSrc=00. It SHALL hold while MemReady=0 and then go to MEMWB.
REQ-020 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-021 MEMWRITE SHALL drive AdrSrc=1, MemReq=1 and MemWrite=1 (level, held while waiting). It SHALL go to FETCH on MemReady=1.
REQ-022 EXECR SHALL drive A=10, B=00; EXECI SHALL drive A=10, B=01. Both SHALL use ALU-decoded control and go to ALUWB.
REQ-023 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-024 JAL SHALL drive A=01, B=10, add, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-025 JALR SHALL drive A=10, B=01, add, then go to JAL; PC thus receives rs1+imm and rd receives OldPC+4.
REQ-026 LUI SHALL drive A=11, B=01, add; AUIPC SHALL drive A=01, B=01, add; both SHALL go to ALUWB.
REQ-027 BRANCH SHALL drive A=10, B=00, sub, ResultSrc=00 and go to FETCH. PCWrite SHALL be asserted by funct3: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu.
REQ-028 ALUControl encodings SHALL be: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001.
REQ-029 The ALU decode for EXECR/EXECI SHALL map funct3 as follows: 000 add, or sub only when R-type and funct7b5=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when funct7b5=1; 110 or; 111 and.
REQ-030 ImmSrc SHALL be combinational from op: I for lw, I-ALU and jalr; S for sw; B for branch; J for jal; U for lui and auipc; 000 otherwise.
REQ-031 Outputs not listed for a state SHALL be 0, with ALUControl=add.
REQ-032 With MEM_HANDSHAKE=0, every memory state SHALL take exactly one cycle.

Reset
REQ-033 reset=0 sampled at a rising edge SHALL load FETCH from any state, including mid-wait.
REQ-034 While reset=0, IRWrite, PCWrite, RegWrite, MemWrite, MemReq and Illegal SHALL be forced 0.
REQ-035 The first cycle after reset=1 SHALL be FETCH with MemReq=1.

Verification
REQ-036 The bench SHALL cover: MEM_HANDSHAKE=1, lw, MemReady low for 2 cycles in both FETCH and MEMREAD -> state trace 0,0,0,1,2,3,3,3,4,0, with IRWrite=1 only on the third FETCH cycle and RegWrite=1 only in state 4.
REQ-037 The bench SHALL cover: bne with Zero=0, then bne with Zero=1 -> PCWrite=1 in BRANCH for the first and 0 for the second, ALUControl=0001 in both.
REQ-038 The bench SHALL cover: jalr -> trace 1,11,9,7,0; state 11 drives A=10, B=01; state 9 drives PCWrite=1; state 7 drives RegWrite=1.
REQ-039 The bench SHALL cover: sub R-type (funct3 000, funct7b5=1) -> ALUControl=0001 in EXECR; addi with funct7b5=1 -> 0000 in EXECI; srai -> 1001.
REQ-040 The bench SHALL cover: SUPPORT_UPPER=0 with lui -> Illegal=1 in DECODE for one cycle, no writes, next state 0.
REQ-041 The bench SHALL cover: sw held in MEMWRITE with MemReady=0 and reset driven 0 -> MemWrite=0 in that cycle and State=0 in the next.
